// File: rtl/uart_tx.sv
// Double-buffered UART transmitter on an 8x bit-rate clock: programmable data
// width (1..16) and optional even/odd parity.
//
// state  | meaning
// IDLE   | line high, waiting for the holding register to fill
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit, computed when the word was loaded
// STOP   | stop bit (high); done pulses on its last cycle
module uart_tx (
    input  logic        clock_x8,
    input  logic        reset,
    input  logic [1:0]  parity,
    input  logic [3:0]  width,
    input  logic        wr,
    input  logic [15:0] bits,
    output logic        out,
    output logic        ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      r_state;
    logic [2:0]  r_step;
    logic [15:0] r_hold;
    logic [15:0] r_shift;
    logic [3:0]  r_last;
    logic [3:0]  r_bitcnt;
    logic        r_par_en;
    logic        r_par_bit;
    logic        r_out;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_load;
    logic [15:0] w_src;
    logic [15:0] w_mask;
    logic        w_par;

    assign w_accept = wr && r_ready;
    // A write landing on the final stop edge goes straight into the shifter
    // so the next start bit follows without an idle cycle.
    assign w_load   = ((r_state == S_IDLE) && !r_ready) ||
                      ((r_state == S_STOP) && (r_step == 3'd0) && (!r_ready || wr));
    assign w_src    = r_ready ? bits : r_hold;
    assign w_mask   = (width == 4'd0) ? 16'hFFFF : ~(16'hFFFF << width);
    assign w_par    = (^(w_src & w_mask)) ^ parity[0];

    always_ff @(posedge clock_x8 or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_step    <= 3'd0;
            r_hold    <= 16'h0000;
            r_shift   <= 16'h0000;
            r_last    <= 4'd0;
            r_bitcnt  <= 4'd0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_out     <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_load) begin
                r_hold  <= bits;
                r_ready <= 1'b0;
            end
            if (w_load) begin
                r_shift   <= w_src;
                r_last    <= width - 4'd1;
                r_par_en  <= parity[1];
                r_par_bit <= w_par;
                r_state   <= S_START;
                r_step    <= 3'd7;
                r_out     <= 1'b0;
                r_busy    <= 1'b1;
                r_ready   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_START: begin
                        if (r_step == 3'd0) begin
                            r_state  <= S_DATA;
                            r_step   <= 3'd7;
                            r_out    <= r_shift[0];
                            r_bitcnt <= 4'd0;
                        end else begin
                            r_step <= r_step - 3'd1;
                        end
                    end
                    S_DATA: begin
                        if (r_step == 3'd0) begin
                            r_step <= 3'd7;
                            if (r_bitcnt == r_last) begin
                                if (r_par_en) begin
                                    r_state <= S_PARITY;
                                    r_out   <= r_par_bit;
                                end else begin
                                    r_state <= S_STOP;
                                    r_out   <= 1'b1;
                                end
                            end else begin
                                r_shift  <= {1'b0, r_shift[15:1]};
                                r_out    <= r_shift[1];
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end
                        end else begin
                            r_step <= r_step - 3'd1;
                        end
                    end
                    S_PARITY: begin
                        if (r_step == 3'd0) begin
                            r_state <= S_STOP;
                            r_step  <= 3'd7;
                            r_out   <= 1'b1;
                        end else begin
                            r_step <= r_step - 3'd1;
                        end
                    end
                    S_STOP: begin
                        if (r_step == 3'd0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_out   <= 1'b1;
                        end else begin
                            r_step <= r_step - 3'd1;
                            if (r_step == 3'd1)
                                r_done <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out   = r_out;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide ports: clock_x8  input  1  bit-rate clock, 8 cycles per UART bit; single clock domain.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: parity  input  2  [1] parity enable, [0] parity sense (0 even, 1 odd).
REQ-004 SHALL provide: width  input  4  data bits per frame, 1..15; 0 means 16.
REQ-005 SHALL provide: wr  input  1  write strobe, sampled on rising clock_x8.
REQ-006 SHALL provide: bits  input  16  word to send, LSB sent first, bits above width ignored.
REQ-007 SHALL provide: out  output  1  serial line, idle high.
REQ-008 SHALL provide: ready  output  1  holding register empty, write accepted.
REQ-009 SHALL provide: busy  output  1  frame in progress on out.
REQ-010 SHALL provide: done  output  1  one-cycle pulse at end of each stop bit.

Function
REQ-011 SHALL hold one word in a holding register and one in the shift register (double buffered).
REQ-012 SHALL accept a write only on an edge where wr=1 and ready=1: captures bits, sets ready=0; wr with ready=0 SHALL be ignored.
REQ-013 SHALL have states IDLE, START, DATA, PARITY, STOP; every bit lasts exactly 8 clock_x8 cycles via a 3-bit step counter.
REQ-014 In IDLE with holding full, SHALL on the next edge move word to shift register, sample parity and width, set ready=1, busy=1, enter START, drive out=0.
REQ-015 Latency: write accepted at edge N while IDLE -> out falls after edge N+1.
REQ-016 DATA SHALL send width bits (16 when width=0), bit i = word[i], then go to PARITY if sampled parity[1]=1, else STOP.
REQ-017 Parity bit SHALL equal XOR of the sent data bits XOR parity[0].
REQ-018 STOP SHALL drive out=1 for 8 cycles; on its last cycle done=1 for exactly one cycle.
REQ-019 At end of STOP, if holding full, SHALL enter START on the next edge with no idle gap; else IDLE, busy=0, out=1.
REQ-020 A write accepted on the same edge the holding register is loaded into the shifter is impossible (ready=0 then); a write on the edge ending STOP SHALL be sent back-to-back.
REQ-021 Changes to parity or width mid-frame SHALL not affect the frame in progress.
REQ-022 out SHALL be registered, glitch-free, and change only on clock_x8 edges (except reset).

Reset
REQ-023 reset=0 SHALL asynchronously force out=1, ready=1, busy=0, done=0, state IDLE, step=0, holding and shift contents discarded.
REQ-024 Reset mid-frame SHALL abort the frame immediately; no done pulse; first frame after release behaves per REQ-014.

Verification
REQ-025 width=8, parity=00, write 0x00A5 in IDLE -> out per 8-cycle bit: 0,1,0,1,0,0,1,0,1,1; 80 cycles; done once; busy falls after.
REQ-026 width=8, write 0x00A5 with parity=10 -> parity bit 0; with parity=11 -> parity bit 1; frame 88 cycles.
REQ-027 width=0, parity=00, write 0x8001 -> start, 1, fourteen 0s, 1, stop; 144 cycles.
REQ-028 Write 0x0055 then 0x00AA while first frame in progress -> ready low until second load, second start bit immediately after first stop, two done pulses 80 cycles apart.
REQ-029 Write while ready=0 with 0x00FF -> ignored; only previously accepted words transmitted.
REQ-030 Assert reset at DATA bit 3 -> out=1, busy=0, ready=1 same cycle; new write after release sends full correct frame.
